// File: rtl/day2_pkg.sv
// Shared types and constant helpers for the day-2 repeated-digit ID solver.
package day2_pkg;

  typedef enum logic {
    MODE_TWICE  = 1'b0,
    MODE_REPEAT = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } lane_state_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_JOB    = 2'd1,
    R_REDUCE = 2'd2,
    R_DONE   = 2'd3
  } red_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int DIV_TAB_W = 32;

  // Decimal digits needed for a W-bit unsigned value: ceil(W * log10(2)).
  function automatic int max_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  // Bit d set when d is a proper divisor of n (1 <= d < n, n % d == 0).
  function automatic logic [DIV_TAB_W-1:0] proper_divisors(input int n);
    logic [DIV_TAB_W-1:0] m;
    m = '0;
    for (int d = 1; d < DIV_TAB_W; d++) begin
      if (d < n && (n % d) == 0) m[d] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/day2_bcd_scan_lane.sv
// One scan lane: converts the range start to BCD, then walks the range one ID per
// cycle, classifies each ID from its decimal digits and accumulates the invalid ones.
module day2_bcd_scan_lane
  import day2_pkg::*;
#(
  parameter int W     = 48,
  parameter int SUM_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  mode_e            mode,
  input  logic [W-1:0]     load_start,
  input  logic [W-1:0]     load_end,
  output logic             idle,
  output logic [SUM_W-1:0] acc,
  output logic             carry
);

  localparam int MD = max_digits(W);
  localparam int BW = 4 * MD;
  localparam int NW = $clog2(MD + 1);
  localparam int NT = 1 << NW;
  localparam int CW = $clog2(W + 1);

  // Double-dabble correction: every digit >= 5 gets +3 before the shift.
  function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < MD; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // BCD increment with a ripple digit carry.
  function automatic logic [BW-1:0] bcd_inc(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic          c;
    r = b;
    c = 1'b1;
    for (int i = 0; i < MD; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  lane_state_e       state, state_nxt;
  logic [CW-1:0]     conv_cnt;
  logic [W-1:0]      bin_sh, cur, end_r, val_p1;
  logic [BW-1:0]     cur_bcd;
  logic              inv_p0, inv_p1, vld_p1;
  logic [MD-1:0]     div_tab [NT];
  logic [NW-1:0]     n_dig;
  logic [MD-1:0]     per_ok;
  bcd_digit_t        dig [MD];
  logic [SUM_W:0]    acc_sum;

  for (genvar g = 0; g < NT; g++) begin : g_div
    assign div_tab[g] = MD'(proper_divisors(g));
  end

  assign idle    = (state == IDLE);
  assign acc_sum = {1'b0, acc} + (SUM_W+1)'(val_p1);
  assign carry   = vld_p1 & inv_p1 & acc_sum[SUM_W];

  // Lane sequencing: IDLE -> CONV (W cycles) -> SCAN (one ID per cycle) -> DRAIN -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load && load_start <= load_end) state_nxt = CONV;
      CONV:    if (conv_cnt == CW'(W - 1)) state_nxt = SCAN;
      SCAN:    if (cur == end_r) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM register, conversion counter and check-stage valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      conv_cnt <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= (state == SCAN);
      if (state == IDLE) conv_cnt <= '0;
      else if (state == CONV) conv_cnt <= conv_cnt + CW'(1);
    end
  end

  // Datapath: range load, binary-to-BCD shift, paired binary/BCD counters, check register.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (load) begin
          cur     <= load_start;
          bin_sh  <= load_start;
          end_r   <= load_end;
          cur_bcd <= '0;
        end
      end
      CONV: begin
        cur_bcd <= {dabble_adj(cur_bcd)[BW-2:0], bin_sh[W-1]};
        bin_sh  <= {bin_sh[W-2:0], 1'b0};
      end
      SCAN: begin
        cur     <= cur + W'(1);
        cur_bcd <= bcd_inc(cur_bcd);
      end
      default: ;
    endcase
    val_p1 <= cur;
    inv_p1 <= inv_p0;
  end

  // Classification of cur_bcd: digit count, per-period digit match, then mode decision.
  always_comb begin
    n_dig  = '0;
    per_ok = '1;
    inv_p0 = 1'b0;
    for (int i = 0; i < MD; i++) begin
      dig[i] = cur_bcd[4*i +: 4];
      if (cur_bcd[4*i +: 4] != 4'd0) n_dig = NW'(i + 1);
    end
    for (int d = 1; d < MD; d++) begin
      for (int i = 0; i < MD - d; i++) begin
        if ((i + d) < int'(n_dig) && dig[i] != dig[i+d]) per_ok[d] = 1'b0;
      end
    end
    if (mode == MODE_TWICE) begin
      for (int d = 1; d < MD; d++) begin
        if (2 * d == int'(n_dig) && per_ok[d]) inv_p0 = 1'b1;
      end
    end else begin
      for (int d = 0; d < MD; d++) begin
        if (div_tab[n_dig][d] && per_ok[d]) inv_p0 = 1'b1;
      end
    end
  end

  // Accumulator: cleared at job start, adds every ID the check stage flagged.
  always_ff @(posedge clk) begin
    if (clear) acc <= '0;
    else if (vld_p1 && inv_p1) acc <= acc_sum[SUM_W-1:0];
  end

endmodule

// File: rtl/day2_stream_puzzle.sv
// Streaming day-2 solver: range FIFO, dispatcher to NUM_LANES scan lanes, and a
// serial reduction of the lane accumulators into the job result.
module day2_stream_puzzle
  import day2_pkg::*;
#(
  parameter int W         = 48,
  parameter int SUM_W     = 64,
  parameter int NUM_LANES = 8,
  parameter int DEPTH     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_start,
  input  logic [W-1:0]     in_end,
  input  logic             in_last,
  output logic             busy,
  output logic             sum_valid,
  output logic [SUM_W-1:0] sum,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [W-1:0]         fifo_start [DEPTH];
  logic [W-1:0]         fifo_end   [DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 fifo_empty, fifo_full, push, pop, job_start, last_seen, jobs_quiet;
  mode_e                job_mode;
  red_state_e           red_state, red_nxt;
  logic [NUM_LANES-1:0] lane_idle, lane_carry, disp_sel, avail, pick;
  logic [W-1:0]         disp_start, disp_end;
  logic [SUM_W-1:0]     lane_acc [NUM_LANES];
  logic [LW-1:0]        red_idx;
  logic                 red_last;
  logic [SUM_W-1:0]     red_sel;
  logic [SUM_W:0]       red_sum;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = !fifo_full && !last_seen;
  assign push       = in_valid && in_ready;
  assign job_start  = push && (red_state == R_IDLE || red_state == R_DONE);
  assign avail      = lane_idle & ~disp_sel;
  assign pick       = avail & (~avail + NUM_LANES'(1));
  assign pop        = !fifo_empty && (|avail);
  assign jobs_quiet = last_seen && fifo_empty && !(|disp_sel) && (&lane_idle);
  assign red_last   = (red_idx == LW'(NUM_LANES - 1));
  assign red_sum    = {1'b0, sum} + {1'b0, red_sel};
  assign busy       = (red_state == R_JOB) || (red_state == R_REDUCE);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    day2_bcd_scan_lane #(.W(W), .SUM_W(SUM_W)) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (job_start),
      .load       (disp_sel[g]),
      .mode       (job_mode),
      .load_start (disp_start),
      .load_end   (disp_end),
      .idle       (lane_idle[g]),
      .acc        (lane_acc[g]),
      .carry      (lane_carry[g])
    );
  end

  // Range FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_start[wr_ptr[AW-1:0]] <= in_start;
      fifo_end[wr_ptr[AW-1:0]]   <= in_end;
    end
    if (pop) begin
      disp_start <= fifo_start[rd_ptr[AW-1:0]];
      disp_end   <= fifo_end[rd_ptr[AW-1:0]];
    end
  end

  // FIFO pointers and the registered one-hot dispatch to the lowest idle lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      disp_sel <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      disp_sel <= pop ? pick : '0;
    end
  end

  // Reduction mux: selects the lane accumulator for the current reduction step.
  always_comb begin
    red_sel = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (red_idx == LW'(i)) red_sel = lane_acc[i];
    end
  end

  // Job FSM next state: wait for a job, run it, reduce, hold the result.
  always_comb begin
    red_nxt = red_state;
    case (red_state)
      R_IDLE, R_DONE: if (push) red_nxt = R_JOB;
      R_JOB:          if (jobs_quiet) red_nxt = R_REDUCE;
      R_REDUCE:       if (red_last) red_nxt = R_DONE;
      default:        red_nxt = R_IDLE;
    endcase
  end

  // Job FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) red_state <= R_IDLE;
    else red_state <= red_nxt;
  end

  // Result, sticky overflow, job mode and the last-range latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      sum_valid <= 1'b0;
      overflow  <= 1'b0;
      red_idx   <= '0;
      last_seen <= 1'b0;
      job_mode  <= MODE_TWICE;
    end else begin
      if (job_start) begin
        sum       <= '0;
        sum_valid <= 1'b0;
        overflow  <= 1'b0;
        red_idx   <= '0;
        job_mode  <= mode_e'(mode);
      end else begin
        if (red_state == R_REDUCE) begin
          sum     <= red_sum[SUM_W-1:0];
          red_idx <= red_idx + LW'(1);
          if (red_sum[SUM_W]) overflow <= 1'b1;
          if (red_last) sum_valid <= 1'b1;
        end
        if (|lane_carry) overflow <= 1'b1;
      end
      if (push && in_last) last_seen <= 1'b1;
      else if (red_state == R_REDUCE && red_last) last_seen <= 1'b0;
    end
  end

endmodule

// File: tb/tb_day2_stream_puzzle.sv
// Directed bench: instance a uses the default parameters, instance b is a narrow
// single-lane, two-entry-FIFO build for backpressure and overflow.
module tb_day2_stream_puzzle;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        a_mode, a_in_valid, a_in_last, a_in_ready, a_busy, a_sum_valid, a_overflow;
  logic [47:0] a_in_start, a_in_end;
  logic [63:0] a_sum;

  logic        b_mode, b_in_valid, b_in_last, b_in_ready, b_busy, b_sum_valid, b_overflow;
  logic [15:0] b_in_start, b_in_end;
  logic [15:0] b_sum;

  int total = 0;
  int bad   = 0;

  day2_stream_puzzle #(.W(48), .SUM_W(64), .NUM_LANES(8), .DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(a_mode), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_start(a_in_start), .in_end(a_in_end), .in_last(a_in_last), .busy(a_busy),
    .sum_valid(a_sum_valid), .sum(a_sum), .overflow(a_overflow)
  );

  day2_stream_puzzle #(.W(16), .SUM_W(16), .NUM_LANES(1), .DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_start(b_in_start), .in_end(b_in_end), .in_last(b_in_last), .busy(b_busy),
    .sum_valid(b_sum_valid), .sum(b_sum), .overflow(b_overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    total++;
    bad++;
    $error("FAIL %s timed out", tag);
  endtask

  // Called on a falling edge; returns on the falling edge after the accept.
  task automatic send_a(input logic [47:0] s, input logic [47:0] e, input logic last);
    int n;
    a_in_start = s; a_in_end = e; a_in_last = last; a_in_valid = 1'b1;
    n = 0;
    while (a_in_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) timeout("send_a");
    @(negedge clk);
    a_in_valid = 1'b0; a_in_last = 1'b0;
  endtask

  task automatic send_b(input logic [15:0] s, input logic [15:0] e, input logic last);
    int n;
    b_in_start = s; b_in_end = e; b_in_last = last; b_in_valid = 1'b1;
    n = 0;
    while (b_in_ready !== 1'b1 && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) timeout("send_b");
    @(negedge clk);
    b_in_valid = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic wait_a;
    int n;
    n = 0;
    while (a_sum_valid !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) timeout("wait_a");
  endtask

  task automatic wait_b;
    int n;
    n = 0;
    while (b_sum_valid !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) timeout("wait_b");
  endtask

  logic [47:0] ts [4];
  logic [47:0] te [4];
  logic [63:0] exp0 [4];
  logic [63:0] exp1 [4];
  logic [47:0] ex_s [11];
  logic [47:0] ex_e [11];

  initial begin
    ts[0] = 48'd11;  te[0] = 48'd22;   exp0[0] = 64'd33;   exp1[0] = 64'd33;
    ts[1] = 48'd95;  te[1] = 48'd115;  exp0[1] = 64'd99;   exp1[1] = 64'd210;
    ts[2] = 48'd998; te[2] = 48'd1012; exp0[2] = 64'd1010; exp1[2] = 64'd2009;
    ts[3] = 48'd1;   te[3] = 48'd9;    exp0[3] = 64'd0;    exp1[3] = 64'd0;
    ex_s[0]  = 48'd11;         ex_e[0]  = 48'd22;
    ex_s[1]  = 48'd95;         ex_e[1]  = 48'd115;
    ex_s[2]  = 48'd998;        ex_e[2]  = 48'd1012;
    ex_s[3]  = 48'd1188511880; ex_e[3]  = 48'd1188511890;
    ex_s[4]  = 48'd222220;     ex_e[4]  = 48'd222224;
    ex_s[5]  = 48'd1698522;    ex_e[5]  = 48'd1698528;
    ex_s[6]  = 48'd446443;     ex_e[6]  = 48'd446449;
    ex_s[7]  = 48'd38593856;   ex_e[7]  = 48'd38593862;
    ex_s[8]  = 48'd565653;     ex_e[8]  = 48'd565659;
    ex_s[9]  = 48'd824824821;  ex_e[9]  = 48'd824824827;
    ex_s[10] = 48'd2121212118; ex_e[10] = 48'd2121212124;

    rst_n = 1'b0;
    a_mode = 1'b0; a_in_valid = 1'b0; a_in_last = 1'b0; a_in_start = '0; a_in_end = '0;
    b_mode = 1'b0; b_in_valid = 1'b0; b_in_last = 1'b0; b_in_start = '0; b_in_end = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_sum_valid", 64'(a_sum_valid), 64'd0);
    check("rst_sum", a_sum, 64'd0);
    check("rst_overflow", 64'(a_overflow), 64'd0);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-range jobs in both modes.
    for (int i = 0; i < 4; i++) begin
      a_mode = 1'b0;
      send_a(ts[i], te[i], 1'b1);
      wait_a();
      check($sformatf("m0_range%0d", i), a_sum, exp0[i]);
    end
    check("busy_after_job", 64'(a_busy), 64'd0);
    check("in_ready_after_job", 64'(a_in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      a_mode = 1'b1;
      send_a(ts[i], te[i], 1'b1);
      wait_a();
      check($sformatf("m1_range%0d", i), a_sum, exp1[i]);
    end

    // Full example job, mode 0 then mode 1.
    a_mode = 1'b0;
    for (int i = 0; i < 11; i++) send_a(ex_s[i], ex_e[i], (i == 10));
    check("in_ready_after_last", 64'(a_in_ready), 64'd0);
    check("busy_during_job", 64'(a_busy), 64'd1);
    wait_a();
    check("example_m0", a_sum, 64'd1227775554);
    repeat (5) @(negedge clk);
    check("example_m0_held_valid", 64'(a_sum_valid), 64'd1);
    check("example_m0_held_sum", a_sum, 64'd1227775554);
    check("example_m0_busy", 64'(a_busy), 64'd0);
    a_mode = 1'b1;
    for (int i = 0; i < 11; i++) send_a(ex_s[i], ex_e[i], (i == 10));
    check("new_job_clears_valid", 64'(a_sum_valid), 64'd0);
    wait_a();
    check("example_m1", a_sum, 64'd4174379265);
    check("example_m1_overflow", 64'(a_overflow), 64'd0);

    // Reversed ranges contribute nothing.
    a_mode = 1'b0;
    send_a(48'd50, 48'd40, 1'b1);
    wait_a();
    check("reversed_only", a_sum, 64'd0);
    send_a(48'd50, 48'd40, 1'b0);
    send_a(48'd11, 48'd22, 1'b1);
    wait_a();
    check("reversed_plus_range", a_sum, 64'd33);

    // Narrow instance: accumulator carry sets overflow; a new job clears it.
    b_mode = 1'b1;
    send_b(16'd5000, 16'd9999, 1'b1);
    wait_b();
    check("b_wrapped_sum", 64'(b_sum), 64'd48545);
    check("b_overflow_set", 64'(b_overflow), 64'd1);
    b_mode = 1'b0;
    send_b(16'd11, 16'd22, 1'b1);
    check("b_new_job_overflow", 64'(b_overflow), 64'd0);
    check("b_new_job_valid", 64'(b_sum_valid), 64'd0);
    wait_b();
    check("b_small_sum", 64'(b_sum), 64'd33);
    check("b_small_overflow", 64'(b_overflow), 64'd0);

    // Backpressure with one lane and a two-entry FIFO.
    b_mode = 1'b1;
    send_b(16'd1, 16'd100, 1'b0);
    send_b(16'd101, 16'd200, 1'b0);
    send_b(16'd201, 16'd300, 1'b0);
    check("bp_full_not_ready", 64'(b_in_ready), 64'd0);
    send_b(16'd301, 16'd400, 1'b1);
    wait_b();
    check("bp_sum", 64'(b_sum), 64'd1161);

    // Reset in the middle of a scan, then a clean job.
    a_mode = 1'b0;
    send_a(48'd1, 48'd400, 1'b1);
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(a_in_ready), 64'd1);
    check("midrst_busy", 64'(a_busy), 64'd0);
    check("midrst_sum_valid", 64'(a_sum_valid), 64'd0);
    check("midrst_sum", a_sum, 64'd0);
    check("midrst_overflow", 64'(a_overflow), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_a(48'd11, 48'd22, 1'b1);
    wait_a();
    check("post_reset_job", a_sum, 64'd33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
